// File: rtl/picoview_regs_pkg.sv
// Shared register map, command field positions and FSM encodings for the SPI register dispatcher.
package picoview_regs_pkg;

  localparam logic [31:0] IdValue = 32'h5049_4356;

  localparam int unsigned CmdWriteBit = 7;
  localparam int unsigned CmdRsvdMsb  = 6;
  localparam int unsigned CmdRsvdLsb  = 3;
  localparam int unsigned CmdAddrMsb  = 2;

  localparam logic [2:0] AddrId         = 3'd0;
  localparam logic [2:0] AddrScratch    = 3'd1;
  localparam logic [2:0] AddrGpioOut    = 3'd2;
  localparam logic [2:0] AddrGpioIn     = 3'd3;
  localparam logic [2:0] AddrTxnCount   = 3'd4;
  localparam logic [2:0] AddrAbortCount = 3'd5;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitData = 2'd1;
  localparam logic [1:0] StCommit   = 2'd2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit inputs (each bit independent).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_dispatch.sv
// Decodes SPI command/data pulses into register reads and writes.
// Transaction counters are built only when SPI_REG_DISPATCH_COUNTERS_EN is defined.
module spi_reg_dispatch
  import picoview_regs_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned COMMAND_SIZE = 8,
  parameter int unsigned GPIO_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COMMAND_SIZE-1:0] command,
  input  logic                    command_ready,
  input  logic [WORD_SIZE-1:0]    word_received,
  input  logic                    word_rx_complete,
  output logic [WORD_SIZE-1:0]    word_to_output,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  output logic                    cmd_error
);

  logic [CmdAddrMsb:0] cmd_addr;
  logic                cmd_write;
  logic                cmd_illegal;

  assign cmd_addr    = command[CmdAddrMsb:0];
  assign cmd_write   = command[CmdWriteBit];
  assign cmd_illegal = |command[CmdRsvdMsb:CmdRsvdLsb];

  logic [1:0]           state_q, state_d;
  logic                 wr_q;
  logic [CmdAddrMsb:0]  addr_q;
  logic [WORD_SIZE-1:0] word_q;
  logic [WORD_SIZE-1:0] scratch_q;
  logic [WORD_SIZE-1:0] gpio_q;
  logic                 cmd_error_q;
  logic [GPIO_WIDTH-1:0] gpio_sync;
  logic [WORD_SIZE-1:0] txn_count;
  logic [WORD_SIZE-1:0] abort_count;

  logic accept_cmd;
  logic abort;
  logic commit;
  logic capture_word;

  sync_2ff #(
    .WIDTH (GPIO_WIDTH)
  ) u_gpio_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (gpio_in),
    .q_o     (gpio_sync)
  );

  always_comb begin
    state_d      = state_q;
    accept_cmd   = 1'b0;
    abort        = 1'b0;
    commit       = 1'b0;
    capture_word = 1'b0;
    case (state_q)
      StIdle: begin
        if (command_ready) accept_cmd = 1'b1;
      end
      StWaitData: begin
        // A new command while waiting means CS dropped: the pending write is lost.
        if (command_ready) begin
          abort      = 1'b1;
          accept_cmd = 1'b1;
        end else if (word_rx_complete) begin
          capture_word = 1'b1;
          state_d      = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
        if (command_ready) accept_cmd = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (accept_cmd) state_d = cmd_illegal ? StIdle : StWaitData;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      word_q      <= '0;
      scratch_q   <= '0;
      gpio_q      <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_error_q <= accept_cmd & cmd_illegal;
      if (accept_cmd && !cmd_illegal) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
      end
      if (capture_word) word_q <= word_received;
      if (commit && wr_q) begin
        if (addr_q == AddrScratch) scratch_q <= word_q;
        if (addr_q == AddrGpioOut) gpio_q    <= word_q;
      end
    end
  end

`ifdef SPI_REG_DISPATCH_COUNTERS_EN
  logic [WORD_SIZE-1:0] txn_q, abort_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_q   <= '0;
      abort_q <= '0;
    end else begin
      if (commit && (txn_q != '1))  txn_q   <= txn_q + 1'b1;
      if (abort && (abort_q != '1)) abort_q <= abort_q + 1'b1;
    end
  end

  assign txn_count   = txn_q;
  assign abort_count = abort_q;
`else
  assign txn_count   = '0;
  assign abort_count = '0;
`endif

  // Front end samples this on the cycle after command_ready, so no register stage here.
  always_comb begin
    word_to_output = '0;
    case (cmd_addr)
      AddrId:         word_to_output = WORD_SIZE'(IdValue);
      AddrScratch:    word_to_output = scratch_q;
      AddrGpioOut:    word_to_output = gpio_q;
      AddrGpioIn:     word_to_output = WORD_SIZE'(gpio_sync);
      AddrTxnCount:   word_to_output = txn_count;
      AddrAbortCount: word_to_output = abort_count;
      default:        word_to_output = '0;
    endcase
  end

  assign gpio_out  = gpio_q[GPIO_WIDTH-1:0];
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_spi_reg_dispatch.sv
// Randomized self-checking bench for spi_reg_dispatch against a transaction-level model.
module tb_spi_reg_dispatch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  command = 8'h00;
  logic        command_ready = 1'b0;
  logic [31:0] word_received = 32'h0;
  logic        word_rx_complete = 1'b0;
  logic [31:0] word_to_output;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        cmd_error;

  spi_reg_dispatch dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .command          (command),
    .command_ready    (command_ready),
    .word_received    (word_received),
    .word_rx_complete (word_rx_complete),
    .word_to_output   (word_to_output),
    .gpio_in          (gpio_in),
    .gpio_out         (gpio_out),
    .cmd_error        (cmd_error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Transaction-level model state
  logic [31:0] m_scratch, m_gpio, m_txn, m_abort;
  logic [7:0]  m_gpio_in;
  bit          m_pending;
  bit          m_wr;
  logic [2:0]  m_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'h5049_4356;
      3'd1: return m_scratch;
      3'd2: return m_gpio;
      3'd3: return {24'h0, m_gpio_in};
`ifdef SPI_REG_DISPATCH_COUNTERS_EN
      3'd4: return m_txn;
      3'd5: return m_abort;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_scratch = '0;
    m_gpio    = '0;
    m_txn     = '0;
    m_abort   = '0;
    m_pending = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    check_eq("rst_cmd_error", {31'h0, cmd_error}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("rst_read", word_to_output, model_read(command[2:0]));
  endtask

  task automatic send_cmd(input logic [7:0] c, input bit with_word, input logic [31:0] w);
    bit illegal;
    illegal = (c[6:3] != 4'h0);
    command       = c;
    command_ready = 1'b1;
    if (with_word) begin
      word_received    = w;
      word_rx_complete = 1'b1;
    end
    tick();
    command_ready    = 1'b0;
    word_rx_complete = 1'b0;
    if (m_pending) m_abort = inc_sat(m_abort);
    m_pending = !illegal;
    m_wr      = c[7];
    m_addr    = c[2:0];
    check_eq("cmd_error", {31'h0, cmd_error}, {31'h0, illegal});
    check_eq("cmd_read", word_to_output, model_read(c[2:0]));
    if (illegal) begin
      tick();
      check_eq("cmd_error_pulse", {31'h0, cmd_error}, 32'h0);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    word_received    = w;
    word_rx_complete = 1'b1;
    tick();
    word_rx_complete = 1'b0;
    word_received    = $urandom;
    tick();
    if (m_pending) begin
      if (m_wr && m_addr == 3'd1) m_scratch = w;
      if (m_wr && m_addr == 3'd2) m_gpio = w;
      m_txn     = inc_sat(m_txn);
      m_pending = 0;
    end
    check_eq("gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio[7:0]});
    check_eq("post_read", word_to_output, model_read(command[2:0]));
  endtask

  task automatic set_gpio(input logic [7:0] v);
    gpio_in = v;
    repeat (3) tick();
    m_gpio_in = v;
  endtask

  initial begin
    logic [7:0] c;
    int unsigned r;
    m_gpio_in = 8'h00;
    model_clear();

    do_reset();

    // Directed scenarios
    send_cmd(8'h00, 0, 0);
    send_word($urandom);
    send_cmd(8'h81, 0, 0);
    send_word(32'hDEAD_BEEF);
    send_cmd(8'h01, 0, 0);
    check_eq("scratch_deadbeef", word_to_output, 32'hDEAD_BEEF);
    send_word($urandom);
    send_cmd(8'h04, 0, 0);
    send_word($urandom);
    send_cmd(8'h82, 0, 0);
    send_word(32'h0000_00A5);
    check_eq("gpio_out_a5", {24'h0, gpio_out}, 32'h0000_00A5);
    send_cmd(8'h81, 0, 0);
    send_cmd(8'h01, 0, 0);
    check_eq("scratch_kept", word_to_output, 32'hDEAD_BEEF);
    send_cmd(8'h05, 0, 0);
    send_word($urandom);
    send_cmd(8'h48, 0, 0);
    send_word(32'h1234_5678);
    set_gpio(8'h3C);
    send_cmd(8'h03, 0, 0);
    check_eq("gpio_in_3c", word_to_output, 32'h0000_003C);
    send_word($urandom);
    send_cmd(8'h04, 0, 0);
    send_word($urandom);
    send_cmd(8'h81, 0, 0);
    send_cmd(8'h02, 1, 32'hFFFF_FFFF);
    send_word($urandom);

    // Reset in the middle of a write discards it
    send_cmd(8'h81, 0, 0);
    do_reset();
    send_word(32'hCAFE_F00D);
    send_cmd(8'h01, 0, 0);
    check_eq("scratch_after_rst", word_to_output, 32'h0);
    send_word($urandom);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        set_gpio(8'($urandom));
      end else if (r < 16) begin
        send_word($urandom);
      end else if (r < 24) begin
        c = 8'($urandom);
        if (c[6:3] == 4'h0) c[3] = 1'b1;
        send_cmd(c, 0, 0);
      end else if (r < 32) begin
        c = 8'($urandom);
        c[6:3] = 4'h0;
        send_cmd(c, 1, $urandom);
      end else begin
        c = 8'($urandom);
        c[6:3] = 4'h0;
        send_cmd(c, 0, 0);
        if ($urandom_range(0, 3) != 0) send_word($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_dispatch.md
SPI_REG_DISPATCH -- requirements
Module: spi_reg_dispatch

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data word width.
REQ-002 SHALL have parameter COMMAND_SIZE, default 8, command width.
REQ-003 SHALL have parameter GPIO_WIDTH, default 8, GPIO in/out width.
REQ-004 SHALL have ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- command  input  COMMAND_SIZE  command byte from the SPI front end; stable from command_ready until the next transaction.
- command_ready  input  1  one-cycle pulse: command is valid.
- word_received  input  WORD_SIZE  write data from the SPI front end.
- word_rx_complete  input  1  one-cycle pulse: word_received is valid.
- word_to_output  output  WORD_SIZE  read data to the SPI front end.
- gpio_in  input  GPIO_WIDTH  asynchronous board inputs.
- gpio_out  output  GPIO_WIDTH  registered board outputs.
- cmd_error  output  1  one-cycle pulse on an illegal command.

Function
REQ-005 SHALL decode command[7] as the write flag, command[2:0] as the address, and command[6:3] as reserved; a nonzero reserved field is an illegal command.
REQ-006 SHALL drive word_to_output combinationally from command[2:0] and the current register state, with zero added latency, because the front end samples it on the cycle after command_ready.
REQ-007 SHALL implement this register map:
- 0: ID, read-only, 0x50494356.
- 1: SCRATCH, read/write.
- 2: GPIO_OUT, read/write; low GPIO_WIDTH bits drive gpio_out.
- 3: GPIO_IN, read-only; synchronized gpio_in, zero-extended.
- 4: TXN_COUNT, read-only.
- 5: ABORT_COUNT, read-only.
- 6-7: read as 0; writes are ignored.
REQ-008 SHALL use three FSM states: IDLE, WAIT_DATA, COMMIT.
REQ-009 IDLE: on command_ready with a legal command, go to WAIT_DATA; with an illegal command, pulse cmd_error on the next cycle and stay in IDLE.
REQ-010 WAIT_DATA: on word_rx_complete, go to COMMIT; on a new command_ready (the previous transfer was aborted by CS), discard the pending write, increment ABORT_COUNT, and decode the new command as in IDLE.
REQ-011 COMMIT: if the write flag is set and the address is writable, load word_received into the addressed register; increment TXN_COUNT for every completed read or write; return to IDLE after one cycle.
REQ-012 SHALL leave register state unchanged by read commands; the word shifted in during a read is discarded.
REQ-013 SHALL saturate TXN_COUNT and ABORT_COUNT at 0xFFFFFFFF, with no wrap.
REQ-014 SHALL ignore word_rx_complete in IDLE.
REQ-015 If command_ready and word_rx_complete coincide in WAIT_DATA, SHALL treat the case as an abort plus a new command; the write is not committed.
REQ-016 SHALL pass gpio_in through a two-flop synchronizer; GPIO_IN reflects a gpio_in change within 2 clk cycles.
REQ-017 SHALL register gpio_out; it updates on the cycle after COMMIT.

Reset
REQ-018 On reset_n low, SHALL asynchronously clear state to IDLE and clear SCRATCH, GPIO_OUT, the counters, the synchronizer flops, gpio_out, and cmd_error.
REQ-019 Reset asserted mid-transaction SHALL discard any pending write, with no counter increment.

Configuration
REQ-020 Macro SPI_REG_DISPATCH_COUNTERS_EN:
- Defined: TXN_COUNT and ABORT_COUNT are implemented as above.
- Undefined: no counter flops; addresses 4-5 read as 0; FSM behaviour is otherwise identical.

Structure
REQ-021 Shared package picoview_regs_pkg SHALL hold the register address constants, the ID constant 0x50494356, the command bit positions, and the FSM state encodings.
REQ-022 The synchronizer SHALL be a sub-module named sync_2ff, parameterized by width.

Verification
REQ-023 Reset, then command 0x00 -> word_to_output = 0x50494356 on the cycle after command_ready.
REQ-024 Command 0x81, word 0xDEADBEEF, then command 0x01 -> read returns 0xDEADBEEF; TXN_COUNT = 2.
REQ-025 Command 0x82, word 0x000000A5 -> gpio_out = 0xA5 one cycle after COMMIT.
REQ-026 Command 0x81, then a second command_ready before word_rx_complete -> SCRATCH unchanged; ABORT_COUNT = 1.
REQ-027 Command 0x48 -> cmd_error pulses for 1 cycle; FSM stays IDLE; TXN_COUNT unchanged.
REQ-028 gpio_in = 0x3C, wait 3 cycles, command 0x03 -> read returns 0x0000003C; with the macro undefined, command 0x04 reads 0.
